alu_cmd_sequencer: RTL
======================

Name: alu_cmd_sequencer

Overview:
- Sequential command front-end for the combinational `alu`. It drives the ALU's `a`/`b`/`opcode` inputs and reads back its `out`/`zero`/`carry`/`overflow`/`sign` results.
- Accepts tagged operation requests over a valid/ready handshake, checks the opcode, and registers each result with its flags.
- Returns results in order through a 2-entry response FIFO.
- Keeps sticky carry/overflow flags and an operation counter for software and bench observation.

Parameters:
- WIDTH, 32, operand/result width; must match the attached `alu`.
- TAG_W, 4, width of the request tag returned with each response.
- RSP_DEPTH, 2, response FIFO depth; legal values are 2 or 4.

Ports:
- clk  in  1  single clock; everything is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- req_opcode  in  4  ALU opcode.
- req_tag  in  TAG_W  request tag.
- alu_a  out  WIDTH  drives alu.a.
- alu_b  out  WIDTH  drives alu.b.
- alu_opcode  out  4  drives alu.opcode.
- alu_out  in  WIDTH  from alu.out.
- alu_zero  in  1  from alu.zero.
- alu_carry  in  1  from alu.carry.
- alu_overflow  in  1  from alu.overflow.
- alu_sign  in  1  from alu.sign.
- rsp_valid  out  1  response FIFO non-empty.
- rsp_ready  in  1  consumer accepts head response.
- rsp_data  out  WIDTH  result.
- rsp_flags  out  4  {zero,carry,overflow,sign}.
- rsp_err  out  1  illegal opcode.
- rsp_tag  out  TAG_W  tag of the request.
- sticky_carry  out  1  OR of carry across completed legal ops.
- sticky_ovf  out  1  OR of overflow across completed legal ops.
- clr_sticky  in  1  clears both sticky flags.
- op_count  out  16  count of responses pushed; wraps.

Behaviour:
- Reset (async assert, sync release): all of the following go to 0 — state IDLE, FIFO empty, rsp_valid, rsp_data, rsp_flags, rsp_err, rsp_tag, alu_a, alu_b, alu_opcode, sticky flags, op_count. req_ready is 0 while rst_n is low.
- Legal opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0111 SLL, 1000 SRL, 1001 SRA.
  - All others (0101, 0110, 1010–1111) are illegal.
- FSM has two states, IDLE and EXEC.
  - IDLE: req_ready = (fifo_count < RSP_DEPTH). On req_valid & req_ready, latch a, b, opcode and tag into the operand registers and go to EXEC.
  - EXEC: req_ready = 0. The ALU settles combinationally from the registered alu_* outputs. At the end of EXEC, push {alu_out, flags, err=0, tag} and return to IDLE.
  - EXEC with an illegal opcode: push {data=0, flags=0, err=1, tag} instead. Sticky flags are not updated.
- Latency and throughput:
  - Request accepted at edge N; response visible at rsp_valid after edge N+2 when the FIFO was empty.
  - Maximum throughput is one op per 2 cycles.
- alu_a, alu_b and alu_opcode hold their last values outside EXEC; they are never X after reset.
- Response FIFO:
  - Strictly in order.
  - rsp_* reflects the head entry; rsp_* is 0 when empty.
  - A pop occurs on rsp_valid & rsp_ready.
  - A push and pop in the same cycle keeps the count unchanged.
  - Overflow is impossible because acceptance checks the count and the count cannot rise between accept and push. The bench asserts on any push while full.
  - Pop while empty is ignored.
- Sticky flags:
  - Set on a legal push when the corresponding ALU flag is 1.
  - clr_sticky clears them the next cycle.
  - clr_sticky coincident with a setting push: the set wins and the flag stays 1.
- op_count increments on every push, legal or illegal, and wraps 0xFFFF→0.
- Reset asserted mid-EXEC: the in-flight op is discarded with no response; the FIFO is flushed.
- req_* inputs are ignored outside the accept cycle.

Test Plan:
- ADD a=0x00000005 b=0x00000003 tag=1, rsp_ready=1 -> rsp_valid 2 cycles after accept, rsp_data=0x00000008, flags=0000, tag=1, op_count=1.
- ADD a=0x7FFFFFFF b=0x00000001 -> rsp_data=0x80000000, overflow=1, sign=1, sticky_ovf=1. Pulse clr_sticky -> sticky_ovf=0 next cycle.
- ADD a=0xFFFFFFFF b=0x00000001 -> rsp_data=0, zero=1, carry=1, sticky_carry=1.
- Opcode 0101, tag=7 -> rsp_err=1, rsp_data=0, flags=0000, tag=7, sticky flags unchanged, op_count increments.
- Backpressure: rsp_ready=0, issue 3 requests (SUB 0xA-0x3, AND 0xF0F0F0F0&0x0F0F0F0F, SLL 1<<4) -> req_ready drops after 2 responses are queued. Raise rsp_ready -> rsp_data=0x7, 0x0, 0x10 in order with tags preserved.
- Assert rst_n=0 during EXEC -> outputs 0 immediately, no response emitted. After release, SRA 0x80000000>>1 -> 0xC0000000.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - registered command front-end for a combinational ALU
// Accepts tagged requests, executes one op per two cycles, returns results in order.
module alu_cmd_sequencer #(
    parameter int WIDTH     = 32,
    parameter int TAG_W     = 4,
    parameter int RSP_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [3:0]       req_opcode,
    input  logic [TAG_W-1:0] req_tag,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             alu_sign,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             sticky_carry,
    output logic             sticky_ovf,
    input  logic             clr_sticky,
    output logic [15:0]      op_count
);
    localparam int PTR_W = $clog2(RSP_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {S_IDLE, S_EXEC} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TAG_W-1:0] r_tag;

    logic             r_pend;
    logic [WIDTH-1:0] r_pend_data;
    logic [3:0]       r_pend_flags;
    logic             r_pend_err;
    logic [TAG_W-1:0] r_pend_tag;

    logic [WIDTH-1:0] r_fifo_data  [RSP_DEPTH];
    logic [3:0]       r_fifo_flags [RSP_DEPTH];
    logic             r_fifo_err   [RSP_DEPTH];
    logic [TAG_W-1:0] r_fifo_tag   [RSP_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_can_accept;
    logic             w_accept;
    logic             w_legal;
    logic             w_push;
    logic             w_pop;
    logic             w_nonempty;

    // The pending result stage counts as occupied so a push can never find the FIFO full.
    assign w_can_accept = rst_n && (r_state == S_IDLE) &&
                          ((r_count + CNT_W'(r_pend)) < CNT_W'(RSP_DEPTH));
    assign req_ready    = w_can_accept;
    assign w_accept     = req_valid && w_can_accept;
    assign w_push       = r_pend;
    assign w_nonempty   = (r_count != '0);
    assign w_pop        = w_nonempty && rsp_ready;

    always_comb begin
        w_legal = 1'b0;
        case (alu_opcode)
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0111, 4'b1000, 4'b1001: w_legal = 1'b1;
            default:                            w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            r_tag      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                alu_a      <= req_a;
                alu_b      <= req_b;
                alu_opcode <= req_opcode;
                r_tag      <= req_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend       <= 1'b0;
            r_pend_data  <= '0;
            r_pend_flags <= '0;
            r_pend_err   <= 1'b0;
            r_pend_tag   <= '0;
        end else begin
            r_pend <= (r_state == S_EXEC);
            if (r_state == S_EXEC) begin
                r_pend_data  <= w_legal ? alu_out : '0;
                r_pend_flags <= w_legal ? {alu_zero, alu_carry, alu_overflow, alu_sign} : 4'b0000;
                r_pend_err   <= !w_legal;
                r_pend_tag   <= r_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                r_fifo_data[i]  <= '0;
                r_fifo_flags[i] <= '0;
                r_fifo_err[i]   <= 1'b0;
                r_fifo_tag[i]   <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr]  <= r_pend_data;
                r_fifo_flags[r_wr_ptr] <= r_pend_flags;
                r_fifo_err[r_wr_ptr]   <= r_pend_err;
                r_fifo_tag[r_wr_ptr]   <= r_pend_tag;
                r_wr_ptr               <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    assign rsp_valid = w_nonempty;
    assign rsp_data  = w_nonempty ? r_fifo_data[r_rd_ptr]  : '0;
    assign rsp_flags = w_nonempty ? r_fifo_flags[r_rd_ptr] : '0;
    assign rsp_err   = w_nonempty ? r_fifo_err[r_rd_ptr]   : 1'b0;
    assign rsp_tag   = w_nonempty ? r_fifo_tag[r_rd_ptr]   : '0;

    // A setting push overrides a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_carry <= 1'b0;
            sticky_ovf   <= 1'b0;
            op_count     <= '0;
        end else begin
            sticky_carry <= (sticky_carry && !clr_sticky) ||
                            (w_push && !r_pend_err && r_pend_flags[2]);
            sticky_ovf   <= (sticky_ovf && !clr_sticky) ||
                            (w_push && !r_pend_err && r_pend_flags[1]);
            op_count     <= op_count + 16'(w_push);
        end
    end
endmodule
